// File: rtl/sub_hunter.sv
// Automatic shot initiator for the submarine responder: raster hunt plus a
// neighbour target queue that is drained ahead of the scan after every hit.
module sub_hunter #(
    parameter int WIDTH   = 6,
    parameter int QDEPTH  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_start,
    input  logic [1:0] i_map_sel,
    output logic [1:0] o_init_select,
    output logic       o_select_valid,
    output logic [2:0] o_x,
    output logic [2:0] o_y,
    output logic       o_cord_valid,
    input  logic       i_busy,
    input  logic       i_hit,
    input  logic       i_sink,
    input  logic       i_done,
    output logic       o_running,
    output logic       o_finished,
    output logic       o_won,
    output logic       o_error,
    output logic [5:0] o_shot_count,
    output logic [5:0] o_hit_count
);

    localparam int NCELL = WIDTH * WIDTH;
    localparam int QAW   = $clog2(QDEPTH);
    localparam int QCW   = QAW + 1;
    localparam int TW    = $clog2(TIMEOUT) + 1;

    localparam logic [QCW-1:0] QFULL = QCW'(QDEPTH);
    localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]     W4    = 4'(WIDTH);
    localparam logic [2:0]     WLAST = 3'(WIDTH - 1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_INIT    = 4'd1;
    localparam logic [3:0] S_SETTLE  = 4'd2;
    localparam logic [3:0] S_PICK    = 4'd3;
    localparam logic [3:0] S_FIRE    = 4'd4;
    localparam logic [3:0] S_GUARD   = 4'd5;
    localparam logic [3:0] S_WAIT    = 4'd6;
    localparam logic [3:0] S_RESOLVE = 4'd7;
    localparam logic [3:0] S_FINISH  = 4'd8;

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [2:0]       r_x, r_y;
    logic [2:0]       r_cx, r_cy;
    logic             r_scan_end;
    logic [NCELL-1:0] r_fired;
    logic [5:0]       r_queue [QDEPTH];
    logic [QAW-1:0]   r_rptr, r_wptr;
    logic [QCW-1:0]   r_qcount;
    logic             r_gcnt;
    logic [TW-1:0]    r_wcnt;
    logic             r_hit_f, r_done_f;
    logic [5:0]       r_shot_count, r_hit_count;
    logic [1:0]       r_init_select;
    logic             r_finished, r_won, r_error;

    logic [5:0]       w_pop;
    logic             w_pop_fired, w_cur_fired, w_window, w_done_now;
    logic [3:0]       w_nx [4];
    logic [3:0]       w_ny [4];
    logic [3:0]       w_ok;
    logic [3:0]       w_push_en;
    logic [QAW-1:0]   w_push_idx [4];
    logic [QAW-1:0]   w_wptr_push;
    logic [QCW-1:0]   w_qcount_push;
    logic             w_unused;

    function automatic logic [5:0] f_idx(input logic [2:0] fx, input logic [2:0] fy);
        return 6'(fx) * 6'(WIDTH) + 6'(fy);
    endfunction

    // Sink pulses carry no strategic information for this player.
    assign w_unused = i_sink;

    assign w_pop       = r_queue[r_rptr];
    assign w_pop_fired = r_fired[f_idx(w_pop[5:3], w_pop[2:0])];
    assign w_cur_fired = r_fired[f_idx(r_cx, r_cy)];
    assign w_window    = (r_state == S_FIRE) || (r_state == S_GUARD) || (r_state == S_WAIT);
    assign w_done_now  = r_done_f || i_done;

    // Neighbours are widened to 4 bits so x-1 at 0 wraps to 15 and fails the range test.
    always_comb begin
        w_nx[0] = {1'b0, r_x} - 4'd1;  w_ny[0] = {1'b0, r_y};
        w_nx[1] = {1'b0, r_x} + 4'd1;  w_ny[1] = {1'b0, r_y};
        w_nx[2] = {1'b0, r_x};         w_ny[2] = {1'b0, r_y} - 4'd1;
        w_nx[3] = {1'b0, r_x};         w_ny[3] = {1'b0, r_y} + 4'd1;
        w_ok = '0;
        for (int i = 0; i < 4; i++) begin
            if ((w_nx[i] < W4) && (w_ny[i] < W4))
                w_ok[i] = !r_fired[f_idx(w_nx[i][2:0], w_ny[i][2:0])];
        end
    end

    always_comb begin
        logic [QCW-1:0] w_cnt;
        logic [QAW-1:0] w_wp;
        w_cnt     = r_qcount;
        w_wp      = r_wptr;
        w_push_en = '0;
        for (int i = 0; i < 4; i++) begin
            w_push_idx[i] = '0;
            if (w_ok[i] && (w_cnt < QFULL)) begin
                w_push_en[i]  = 1'b1;
                w_push_idx[i] = w_wp;
                w_wp          = w_wp + 1'b1;
                w_cnt         = w_cnt + 1'b1;
            end
        end
        w_wptr_push   = w_wp;
        w_qcount_push = w_cnt;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_next = S_INIT;
            S_INIT:    w_next = S_SETTLE;
            S_SETTLE:  w_next = S_PICK;
            S_PICK: begin
                if (r_qcount != '0) begin
                    if (!w_pop_fired) w_next = S_FIRE;
                end else if (r_scan_end) begin
                    w_next = S_FINISH;
                end else if (!w_cur_fired) begin
                    w_next = S_FIRE;
                end
            end
            S_FIRE:    w_next = S_GUARD;
            S_GUARD:   if (r_gcnt) w_next = S_WAIT;
            S_WAIT: begin
                if (!i_busy || w_done_now) w_next = S_RESOLVE;
                else if (r_wcnt == TLAST)  w_next = S_FINISH;
            end
            S_RESOLVE: w_next = r_done_f ? S_FINISH : S_PICK;
            S_FINISH:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_cx          <= '0;
            r_cy          <= '0;
            r_scan_end    <= 1'b0;
            r_fired       <= '0;
            for (int i = 0; i < QDEPTH; i++) r_queue[i] <= '0;
            r_rptr        <= '0;
            r_wptr        <= '0;
            r_qcount      <= '0;
            r_gcnt        <= 1'b0;
            r_wcnt        <= '0;
            r_hit_f       <= 1'b0;
            r_done_f      <= 1'b0;
            r_shot_count  <= '0;
            r_hit_count   <= '0;
            r_init_select <= '0;
            r_finished    <= 1'b0;
            r_won         <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_window) begin
                r_hit_f  <= r_hit_f | i_hit;
                r_done_f <= r_done_f | i_done;
            end
            if (w_next == S_FINISH) r_finished <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_init_select <= i_map_sel;
                        r_shot_count  <= '0;
                        r_hit_count   <= '0;
                        r_fired       <= '0;
                        r_rptr        <= '0;
                        r_wptr        <= '0;
                        r_qcount      <= '0;
                        r_cx          <= '0;
                        r_cy          <= '0;
                        r_scan_end    <= 1'b0;
                        r_hit_f       <= 1'b0;
                        r_done_f      <= 1'b0;
                        r_finished    <= 1'b0;
                        r_won         <= 1'b0;
                        r_error       <= 1'b0;
                    end
                end
                S_PICK: begin
                    if (r_qcount != '0) begin
                        r_rptr   <= r_rptr + 1'b1;
                        r_qcount <= r_qcount - 1'b1;
                        if (!w_pop_fired) begin
                            r_x <= w_pop[5:3];
                            r_y <= w_pop[2:0];
                        end
                    end else if (!r_scan_end) begin
                        if (!w_cur_fired) begin
                            r_x <= r_cx;
                            r_y <= r_cy;
                        end
                        if (r_cy == WLAST) begin
                            r_cy <= '0;
                            if (r_cx == WLAST) r_scan_end <= 1'b1;
                            else               r_cx <= r_cx + 3'd1;
                        end else begin
                            r_cy <= r_cy + 3'd1;
                        end
                    end
                end
                S_FIRE: begin
                    r_fired[f_idx(r_x, r_y)] <= 1'b1;
                    if (r_shot_count != 6'd63) r_shot_count <= r_shot_count + 6'd1;
                    r_gcnt <= 1'b0;
                end
                S_GUARD: begin
                    r_gcnt <= 1'b1;
                    r_wcnt <= '0;
                end
                S_WAIT: begin
                    r_wcnt <= r_wcnt + 1'b1;
                    if (w_next == S_FINISH) r_error <= 1'b1;
                end
                S_RESOLVE: begin
                    if (r_hit_f) begin
                        if (r_hit_count != 6'd63) r_hit_count <= r_hit_count + 6'd1;
                        for (int i = 0; i < 4; i++) begin
                            if (w_push_en[i])
                                r_queue[w_push_idx[i]] <= {w_nx[i][2:0], w_ny[i][2:0]};
                        end
                        r_wptr   <= w_wptr_push;
                        r_qcount <= w_qcount_push;
                    end
                    if (r_done_f) r_won <= 1'b1;
                    r_hit_f  <= 1'b0;
                    r_done_f <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_init_select  = r_init_select;
    assign o_select_valid = (r_state == S_INIT);
    assign o_x            = r_x;
    assign o_y            = r_y;
    assign o_cord_valid   = (r_state == S_FIRE);
    assign o_running      = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign o_finished     = r_finished;
    assign o_won          = r_won;
    assign o_error        = r_error;
    assign o_shot_count   = r_shot_count;
    assign o_hit_count    = r_hit_count;

endmodule

// File: tb/tb_sub_hunter.sv
// Directed bench for sub_hunter: a small responder model answers every shot
// and records the coordinates so shot order, counts and flags can be checked.
module tb_sub_hunter;

    logic       clk, rstn, start;
    logic [1:0] mapSel, initSelect;
    logic       selectValid, cordValid;
    logic [2:0] x, y;
    logic       busy, hit, sink, done;
    logic       running, finished, won, error;
    logic [5:0] shotCount, hitCount;

    int testsRun  = 0;
    int failCount = 0;

    int shotX [64];
    int shotY [64];
    int shotN       = 0;
    int hitX        = 7;
    int hitY        = 7;
    int doneShot    = 0;
    bit busyForever = 1'b0;
    int phase       = 0;
    bit pendHit     = 1'b0;
    bit pendDone    = 1'b0;

    sub_hunter #(.WIDTH(6), .QDEPTH(8), .TIMEOUT(64)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .i_start        (start),
        .i_map_sel      (mapSel),
        .o_init_select  (initSelect),
        .o_select_valid (selectValid),
        .o_x            (x),
        .o_y            (y),
        .o_cord_valid   (cordValid),
        .i_busy         (busy),
        .i_hit          (hit),
        .i_sink         (sink),
        .i_done         (done),
        .o_running      (running),
        .o_finished     (finished),
        .o_won          (won),
        .o_error        (error),
        .o_shot_count   (shotCount),
        .o_hit_count    (hitCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Responder: busy rises one cycle after the shot, results pulse on the
    // second guard cycle, busy drops on the third unless held forever.
    initial begin
        busy = 1'b0; hit = 1'b0; sink = 1'b0; done = 1'b0;
        forever begin
            @(negedge clk);
            hit = 1'b0; sink = 1'b0; done = 1'b0;
            if (!rstn) phase = 0;
            case (phase)
                1: begin busy = 1'b1; phase = 2; end
                2: begin busy = 1'b1; hit = pendHit; sink = pendHit; done = pendDone; phase = 3; end
                3: begin busy = busyForever; phase = 0; end
                default: if (!busyForever) busy = 1'b0;
            endcase
            if (cordValid && rstn) begin
                if (shotN < 64) begin
                    shotX[shotN] = int'(x);
                    shotY[shotN] = int'(y);
                end
                shotN++;
                pendHit  = (int'(x) == hitX) && (int'(y) == hitY);
                pendDone = (shotN == doneShot);
                phase    = 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] sel);
        shotN = 0;
        @(negedge clk);
        mapSel = sel;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        checkOutput("select_valid_pulse", {31'd0, selectValid}, 1);
        checkOutput("init_select", {30'd0, initSelect}, {30'd0, sel});
        checkOutput("running_after_start", {31'd0, running}, 1);
        @(negedge clk);
        checkOutput("select_valid_one_cycle", {31'd0, selectValid}, 0);
    endtask

    task automatic waitFinished(input string tag);
        int n = 0;
        while (!finished && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_finished"}, {31'd0, finished}, 1);
    endtask

    task automatic waitShot(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cordValid && n < 50);
        checkOutput({tag, "_cord_valid"}, {31'd0, cordValid}, 1);
    endtask

    task automatic checkRaster(input string tag, input int first, input int count);
        for (int i = first; i < first + count; i++)
            checkOutput($sformatf("%s_shot%0d", tag, i), shotX[i] * 10 + shotY[i], (i / 6) * 10 + (i % 6));
    endtask

    task automatic checkUnique(input string tag);
        logic [63:0] seen = '0;
        int dups = 0;
        int outOfRange = 0;
        for (int i = 0; i < shotN && i < 64; i++) begin
            if (shotX[i] > 5 || shotY[i] > 5) outOfRange++;
            else begin
                if (seen[shotX[i] * 6 + shotY[i]]) dups++;
                seen[shotX[i] * 6 + shotY[i]] = 1'b1;
            end
        end
        checkOutput({tag, "_repeats"}, dups, 0);
        checkOutput({tag, "_out_of_range"}, outOfRange, 0);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_running"},      {31'd0, running},     0);
        checkOutput({tag, "_finished"},     {31'd0, finished},    0);
        checkOutput({tag, "_won"},          {31'd0, won},         0);
        checkOutput({tag, "_error"},        {31'd0, error},       0);
        checkOutput({tag, "_cord_valid"},   {31'd0, cordValid},   0);
        checkOutput({tag, "_select_valid"}, {31'd0, selectValid}, 0);
        checkOutput({tag, "_init_select"},  {30'd0, initSelect},  0);
        checkOutput({tag, "_shot_count"},   {26'd0, shotCount},   0);
        checkOutput({tag, "_hit_count"},    {26'd0, hitCount},    0);
        checkOutput({tag, "_xy"},           {26'd0, x, y},        0);
    endtask

    initial begin
        int tailB [5] = '{32, 23, 24, 25, 30};
        int headC [8] = '{0, 10, 1, 2, 3, 4, 5, 11};

        rstn = 1'b0; start = 1'b0; mapSel = 2'd0;
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        rstn = 1'b1;
        @(negedge clk);

        // Game A: no hits, full raster of 36 cells.
        hitX = 7; hitY = 7; doneShot = 0;
        applyStimulus(2'd0);
        waitFinished("A");
        checkOutput("A_won", {31'd0, won}, 0);
        checkOutput("A_error", {31'd0, error}, 0);
        checkOutput("A_running", {31'd0, running}, 0);
        checkOutput("A_shot_count", {26'd0, shotCount}, 36);
        checkOutput("A_hit_count", {26'd0, hitCount}, 0);
        checkOutput("A_shots_seen", shotN, 36);
        checkRaster("A", 0, 36);
        repeat (5) @(negedge clk);
        checkOutput("A_finished_held", {31'd0, finished}, 1);

        // Game B: hit at (2,2); only its unfired neighbours (3,2),(2,3) are queued.
        hitX = 2; hitY = 2;
        applyStimulus(2'd1);
        waitFinished("B");
        checkOutput("B_hit_count", {26'd0, hitCount}, 1);
        checkOutput("B_shot_count", {26'd0, shotCount}, 36);
        checkOutput("B_won", {31'd0, won}, 0);
        checkOutput("B_shots_seen", shotN, 36);
        checkRaster("B", 0, 15);
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("B_shot%0d", 15 + i), shotX[15 + i] * 10 + shotY[15 + i], tailB[i]);
        checkUnique("B");

        // Game C: hit at the corner (0,0); only (1,0),(0,1) are in range.
        hitX = 0; hitY = 0;
        applyStimulus(2'd2);
        waitFinished("C");
        checkOutput("C_hit_count", {26'd0, hitCount}, 1);
        checkOutput("C_shot_count", {26'd0, shotCount}, 36);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("C_shot%0d", i), shotX[i] * 10 + shotY[i], headC[i]);
        checkUnique("C");

        // Game D: responder reports done on the 5th shot.
        hitX = 7; hitY = 7; doneShot = 5;
        applyStimulus(2'd3);
        waitFinished("D");
        checkOutput("D_won", {31'd0, won}, 1);
        checkOutput("D_shot_count", {26'd0, shotCount}, 5);
        checkOutput("D_hit_count", {26'd0, hitCount}, 0);
        repeat (20) @(negedge clk);
        checkOutput("D_no_more_shots", shotN, 5);
        checkOutput("D_finished_held", {31'd0, finished}, 1);
        checkOutput("D_won_held", {31'd0, won}, 1);

        // Game E: busy never drops; error exactly after 64 WAIT_RSP cycles.
        doneShot = 0; busyForever = 1'b1;
        applyStimulus(2'd2);
        checkOutput("E_won_cleared", {31'd0, won}, 0);
        waitShot("E");
        repeat (66) @(negedge clk);
        checkOutput("E_error_not_early", {31'd0, error}, 0);
        checkOutput("E_finished_not_early", {31'd0, finished}, 0);
        @(negedge clk);
        checkOutput("E_error", {31'd0, error}, 1);
        checkOutput("E_finished", {31'd0, finished}, 1);
        checkOutput("E_running", {31'd0, running}, 0);
        checkOutput("E_shot_count", {26'd0, shotCount}, 1);
        checkOutput("E_won", {31'd0, won}, 0);

        // Game F: reset while waiting for a response, then a full replay.
        applyStimulus(2'd2);
        checkOutput("F_error_cleared", {31'd0, error}, 0);
        waitShot("F");
        repeat (10) @(negedge clk);
        checkOutput("F_waiting", {31'd0, running}, 1);
        #2 rstn = 1'b0;
        #1 checkIdleOutputs("midreset");
        busyForever = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        applyStimulus(2'd0);
        waitFinished("F");
        checkOutput("F_shot_count", {26'd0, shotCount}, 36);
        checkOutput("F_shots_seen", shotN, 36);
        checkOutput("F_won", {31'd0, won}, 0);
        checkOutput("F_error", {31'd0, error}, 0);
        checkRaster("F", 0, 2);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
